branch_history_predictor: RTL and testbench
===========================================

Name: branch_history_predictor

Overview:
- Bimodal branch predictor that sits directly upstream of the fetch next-PC mux.
- Supplies `br_pred_taken` and `bp_enable` for the PC currently in fetch.
- Learns branch outcomes from execute-stage resolution through a table of 2-bit saturating counters indexed by PC.
- Provides a clear sweep so software or debug can reset predictor state without a core reset.

Parameters:
- IDX_BITS, 6: log2 of table entries (64 entries); index = pc[IDX_BITS+1:2].
- INIT_CTR, 2'b01: counter value loaded on reset and by the clear sweep (weakly not-taken).

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cfg_enable  input  1  global predictor enable from the CSR.
- lookup_pc  input  32  PC of the instruction in fetch.
- br_pred_taken  output  1  prediction for lookup_pc; combinational from the table.
- bp_enable  output  1  cfg_enable AND state==READY.
- upd_valid  input  1  a resolved conditional branch is present in execute this cycle.
- upd_pc  input  32  PC of the resolved branch.
- upd_taken  input  1  actual branch outcome.
- upd_mispredict  input  1  resolved outcome differed from the prediction (used only by stats).
- clear_req  input  1  single-cycle pulse that starts a clear sweep.
- clear_busy  output  1  high while a sweep is in progress.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all counters = INIT_CTR; state = READY; sweep index = 0.
  - clear_busy = 0; bp_enable = cfg_enable; br_pred_taken = 0.
- Lookup (zero latency): br_pred_taken = ctr[lookup_pc[IDX_BITS+1:2]][1] when state==READY, else 0.
- Update (written at the clock edge when upd_valid && state==READY):
  - idx = upd_pc[IDX_BITS+1:2].
  - taken: ctr = min(ctr+1, 3).
  - not taken: ctr = max(ctr-1, 0).
  - saturation at 3 and at 0 is mandatory; counters never wrap.
- Same index looked up and updated in the same cycle: the lookup returns the pre-update value; no bypass.
- Low PC bits: pc[1:0] are ignored. Aliasing between PCs that share an index is accepted.
- State machine {READY, CLEAR}:
  - READY -> CLEAR on clear_req; sweep index is set to 0.
  - CLEAR: each cycle, ctr[sweep index] = INIT_CTR and the index increments.
  - After writing the last entry (index 2^IDX_BITS-1), return to READY. The sweep takes exactly 2^IDX_BITS cycles.
  - clear_busy = (state==CLEAR), registered.
- During CLEAR:
  - upd_valid is dropped, not queued.
  - br_pred_taken = 0 and bp_enable = 0, so fetch falls back to pc+4.
- clear_req arriving while already in CLEAR is ignored; the sweep does not restart.
- A clear_req in the same cycle as upd_valid: the update is applied in that cycle, and the sweep starts on the next cycle.
- Reset mid-sweep aborts the sweep immediately; the table reinitialises to INIT_CTR.
- cfg_enable low: the table continues to train on updates, but bp_enable = 0.

Optional Feature:
- Macro: BP_STATS_EN.
- When defined, two extra outputs are added:
  - stat_branches [31:0]: counts upd_valid cycles accepted in READY.
  - stat_mispredicts [31:0]: counts accepted updates with upd_mispredict=1.
- Both counters reset to 0 on rst_n and on clear_req, and wrap modulo 2^32.
- When the macro is undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package riscv_bp_pkg contains:
  - counter encodings: SNT=0, WNT=1, WT=2, ST=3;
  - state enum {READY, CLEAR};
  - the default IDX_BITS.
- One natural sub-module: bp_sat_ctr2, the combinational 2-bit saturating next-value function (inputs ctr and taken; output next ctr). It is instantiated once for the update path.

Test Plan:
- Reset, then lookup_pc=0x4000_0000 -> br_pred_taken=0 and bp_enable=1 with cfg_enable=1.
- Two taken updates at upd_pc=0x4000_0010 -> counter 1→2→3; lookup of 0x4000_0010 gives 1. Two more taken updates keep the counter at 3. Three not-taken updates give 3→2→1→0, and then 0 holds.
- Aliasing: update 0x4000_0010 taken ×2 -> lookup of 0x4000_0110 (same index at IDX_BITS=6) also predicts 1; lookup of 0x4000_0014 predicts 0.
- Pulse clear_req -> clear_busy=1 for exactly 64 cycles; bp_enable=0 throughout; an upd_valid mid-sweep is dropped. Afterwards, all previously trained entries predict 0.
- Assert rst_n low at sweep cycle 20 -> clear_busy=0 immediately; after release, state=READY and all entries are at INIT_CTR.
- BP_STATS_EN build: 10 accepted updates with 3 mispredicts -> stat_branches=10, stat_mispredicts=3. Preload stat_branches to 0xFFFF_FFFF, apply one update -> 0.

Source files
------------

// File: rtl/branch_history_predictor_pkg.sv
// Purpose: shared types and defaults for the bimodal branch predictor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package riscv_bp_pkg;

  localparam int DEF_IDX_BITS = 6;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_e;

  typedef enum logic {
    READY = 1'b0,
    CLEAR = 1'b1
  } bp_state_e;

endpackage

// File: rtl/branch_history_predictor_if.sv
// Purpose: fetch lookup, execute update and clear-control bundle for the predictor.
// Latency: n/a (wiring only). Stats outputs exist only when BP_STATS_EN is defined.
// Backpressure: none; updates are fire-and-forget and are dropped while a sweep runs.
interface branch_history_predictor_if;

  logic        cfg_enable;
  logic [31:0] lookup_pc;
  logic        br_pred_taken;
  logic        bp_enable;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        upd_mispredict;
  logic        clear_req;
  logic        clear_busy;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

`ifdef BP_STATS_EN
  modport master (
    output cfg_enable, lookup_pc, upd_valid, upd_pc, upd_taken, upd_mispredict, clear_req,
    input  br_pred_taken, bp_enable, clear_busy, stat_branches, stat_mispredicts
  );

  modport slave (
    input  cfg_enable, lookup_pc, upd_valid, upd_pc, upd_taken, upd_mispredict, clear_req,
    output br_pred_taken, bp_enable, clear_busy, stat_branches, stat_mispredicts
  );
`else
  modport master (
    output cfg_enable, lookup_pc, upd_valid, upd_pc, upd_taken, upd_mispredict, clear_req,
    input  br_pred_taken, bp_enable, clear_busy
  );

  modport slave (
    input  cfg_enable, lookup_pc, upd_valid, upd_pc, upd_taken, upd_mispredict, clear_req,
    output br_pred_taken, bp_enable, clear_busy
  );
`endif

endinterface

// File: rtl/branch_history_predictor_sat_ctr2.sv
// Purpose: next value of a 2-bit saturating counter given the resolved outcome.
// Latency: combinational.
// Backpressure: none.
module bp_sat_ctr2
  import riscv_bp_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_nxt
);

  // Saturate at both ends instead of wrapping.
  always_comb begin
    ctr_nxt = ctr;
    if (taken) begin
      if (ctr != ST) ctr_nxt = ctr + 2'd1;
    end else begin
      if (ctr != SNT) ctr_nxt = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_history_predictor.sv
// Purpose: bimodal predictor (PC-indexed 2-bit counters) with a one-entry-per-cycle clear sweep; BP_STATS_EN adds branch/mispredict counters.
// Latency: lookup is combinational; updates land on the next clk edge; a sweep takes 2^IDX_BITS cycles.
// Backpressure: none; updates arriving during a sweep are dropped and prediction is forced off.
module branch_history_predictor
  import riscv_bp_pkg::*;
#(
  parameter int         IDX_BITS = DEF_IDX_BITS,
  parameter logic [1:0] INIT_CTR = WNT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  branch_history_predictor_if.slave    bp
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic [1:0]          ctr_q [ENTRIES];
  bp_state_e           state_q;
  logic [IDX_BITS-1:0] sweep_idx_q;
  logic [IDX_BITS-1:0] lookup_idx;
  logic [IDX_BITS-1:0] upd_idx;
  logic [1:0]          upd_ctr;
  logic [1:0]          upd_ctr_nxt;
  logic                upd_acc;

  assign lookup_idx = bp.lookup_pc[IDX_BITS+1:2];
  assign upd_idx    = bp.upd_pc[IDX_BITS+1:2];
  assign upd_acc    = bp.upd_valid && (state_q == READY);
  assign upd_ctr    = ctr_q[upd_idx];

  bp_sat_ctr2 u_sat_ctr (
    .ctr     (upd_ctr),
    .taken   (bp.upd_taken),
    .ctr_nxt (upd_ctr_nxt)
  );

  // A clear_req seen in CLEAR is ignored so the sweep never restarts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= READY;
      sweep_idx_q <= '0;
    end else begin
      case (state_q)
        READY: begin
          if (bp.clear_req) begin
            state_q     <= CLEAR;
            sweep_idx_q <= '0;
          end
        end
        CLEAR: begin
          sweep_idx_q <= sweep_idx_q + IDX_BITS'(1);
          if (sweep_idx_q == {IDX_BITS{1'b1}}) state_q <= READY;
        end
        default: state_q <= READY;
      endcase
    end
  end

  // Updates only write in READY, so they cannot collide with a sweep write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= INIT_CTR;
    end else if (state_q == CLEAR) begin
      ctr_q[sweep_idx_q] <= INIT_CTR;
    end else if (upd_acc) begin
      ctr_q[upd_idx] <= upd_ctr_nxt;
    end
  end

  assign bp.clear_busy    = (state_q == CLEAR);
  assign bp.bp_enable     = bp.cfg_enable && (state_q == READY);
  assign bp.br_pred_taken = (state_q == READY) && ctr_q[lookup_idx][1];

`ifdef BP_STATS_EN
  logic [31:0] stat_branches_q;
  logic [31:0] stat_mispredicts_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else if (bp.clear_req) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else if (upd_acc) begin
      stat_branches_q <= stat_branches_q + 32'd1;
      if (bp.upd_mispredict) stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
    end
  end

  assign bp.stat_branches    = stat_branches_q;
  assign bp.stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_history_predictor.sv
// Directed bench for branch_history_predictor: stimulus queues expected outputs, a negedge monitor compares them.
// Stats checks are compiled in only with BP_STATS_EN.
module tb_branch_history_predictor;

  localparam logic [31:0] B = 32'h4000_0000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  branch_history_predictor_if bp_if ();

  branch_history_predictor dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (bp_if.slave)
  );

  typedef struct {
    logic [2:0]  exp;
    bit          chk_stats;
    logic [31:0] sb;
    logic [31:0] sm;
  } exp_t;

  exp_t  sbq[$];
  string nameq[$];
  int    checks = 0;
  int    errors = 0;

  exp_t       mon_e;
  string      mon_nm;
  logic [2:0] mon_got;

  task automatic push(input string nm, input bit pt, input bit en, input bit busy);
    exp_t e;
    e.exp = {pt, en, busy};
    e.chk_stats = 1'b0;
    e.sb = '0;
    e.sm = '0;
    sbq.push_back(e);
    nameq.push_back(nm);
  endtask

  task automatic push_stats(input string nm, input logic [31:0] b, input logic [31:0] m);
    exp_t e;
    e.exp = '0;
    e.chk_stats = 1'b1;
    e.sb = b;
    e.sm = m;
    sbq.push_back(e);
    nameq.push_back(nm);
  endtask

  // Monitor: drains everything queued since the previous falling edge.
  always @(negedge clk) begin
    while (sbq.size() > 0) begin
      mon_e  = sbq.pop_front();
      mon_nm = nameq.pop_front();
      if (!mon_e.chk_stats) begin
        checks++;
        mon_got = {bp_if.br_pred_taken, bp_if.bp_enable, bp_if.clear_busy};
        if (mon_got !== mon_e.exp) begin
          errors++;
          $display("FAIL %s: pred/en/busy got %b required %b", mon_nm, mon_got, mon_e.exp);
        end
      end else begin
`ifdef BP_STATS_EN
        checks++;
        if (bp_if.stat_branches !== mon_e.sb || bp_if.stat_mispredicts !== mon_e.sm) begin
          errors++;
          $display("FAIL %s: branches/mispredicts got %0d/%0d required %0d/%0d", mon_nm,
                   bp_if.stat_branches, bp_if.stat_mispredicts, mon_e.sb, mon_e.sm);
        end
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input bit t, input bit m);
    step();
    bp_if.upd_valid      = 1'b1;
    bp_if.upd_pc         = pc;
    bp_if.upd_taken      = t;
    bp_if.upd_mispredict = m;
    step();
    bp_if.upd_valid      = 1'b0;
  endtask

  task automatic look(input string nm, input logic [31:0] pc, input bit pt);
    step();
    bp_if.lookup_pc = pc;
    push(nm, pt, 1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bp_if.cfg_enable     = 1'b1;
    bp_if.lookup_pc      = B;
    bp_if.upd_valid      = 1'b0;
    bp_if.upd_pc         = '0;
    bp_if.upd_taken      = 1'b0;
    bp_if.upd_mispredict = 1'b0;
    bp_if.clear_req      = 1'b0;
    rst_n                = 1'b0;
    #2 push("reset_state", 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    look("lookup_after_reset", B, 1'b0);

    // Counter walk on index 4: 1 -> 2 -> 3 (hold) -> 2 -> 1 -> 0 (hold) -> 1
    upd(B + 32'h10, 1'b1, 1'b0); look("wnt_to_wt", B + 32'h10, 1'b1);
    upd(B + 32'h10, 1'b1, 1'b0); look("wt_to_st", B + 32'h10, 1'b1);
    upd(B + 32'h10, 1'b1, 1'b0);
    upd(B + 32'h10, 1'b1, 1'b0); look("hold_at_st", B + 32'h10, 1'b1);
    upd(B + 32'h10, 1'b0, 1'b0); look("st_to_wt", B + 32'h10, 1'b1);
    upd(B + 32'h10, 1'b0, 1'b0); look("wt_to_wnt", B + 32'h10, 1'b0);
    upd(B + 32'h10, 1'b0, 1'b0); look("wnt_to_snt", B + 32'h10, 1'b0);
    upd(B + 32'h10, 1'b0, 1'b0);
    upd(B + 32'h10, 1'b1, 1'b0); look("hold_at_snt_then_up", B + 32'h10, 1'b0);

    // Lookup and update of the same index in one cycle: no bypass
    step();
    bp_if.lookup_pc = B + 32'h10;
    bp_if.upd_valid = 1'b1;
    bp_if.upd_pc    = B + 32'h10;
    bp_if.upd_taken = 1'b1;
    push("same_cycle_pre_update", 1'b0, 1'b1, 1'b0);
    step();
    bp_if.upd_valid = 1'b0;
    push("same_cycle_post_update", 1'b1, 1'b1, 1'b0);

    upd(B + 32'h10, 1'b1, 1'b0);
    look("alias_same_index", B + 32'h110, 1'b1);
    look("neighbour_index", B + 32'h14, 1'b0);
    upd(B + 32'h80, 1'b1, 1'b0);
    look("second_entry", B + 32'h80, 1'b1);

    // Training continues while the predictor is disabled
    step();
    bp_if.cfg_enable = 1'b0;
    bp_if.lookup_pc  = B + 32'h10;
    push("cfg_off", 1'b1, 1'b0, 1'b0);
    upd(B + 32'h14, 1'b1, 1'b0);
    step();
    bp_if.cfg_enable = 1'b1;
    bp_if.lookup_pc  = B + 32'h14;
    push("trained_while_off", 1'b1, 1'b1, 1'b0);

    // Full sweep with a dropped update and an ignored second clear_req
    step();
    bp_if.clear_req = 1'b1;
    bp_if.lookup_pc = B + 32'h10;
    push("clear_req_cycle", 1'b1, 1'b1, 1'b0);
    step();
    bp_if.clear_req = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      push($sformatf("sweep_cycle_%0d", k), 1'b0, 1'b0, 1'b1);
      if (k == 10) begin
        bp_if.upd_valid = 1'b1;
        bp_if.upd_pc    = B + 32'h10;
        bp_if.upd_taken = 1'b1;
      end
      if (k == 11) bp_if.upd_valid = 1'b0;
      if (k == 30) bp_if.clear_req = 1'b1;
      if (k == 31) bp_if.clear_req = 1'b0;
      step();
    end
    push("sweep_done", 1'b0, 1'b1, 1'b0);
    look("cleared_idx5", B + 32'h14, 1'b0);
    look("cleared_idx32", B + 32'h80, 1'b0);
    look("cleared_alias", B + 32'h110, 1'b0);

    // Reset in the middle of a sweep
    upd(B + 32'h10, 1'b1, 1'b0);
    upd(B + 32'h10, 1'b1, 1'b0);
    step();
    bp_if.clear_req = 1'b1;
    step();
    bp_if.clear_req = 1'b0;
    repeat (20) step();
    rst_n = 1'b0;
    #1 push("reset_mid_sweep", 1'b0, 1'b1, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    look("post_reset_entry", B + 32'h10, 1'b0);
    upd(B + 32'h10, 1'b1, 1'b0); look("post_reset_init_ctr", B + 32'h10, 1'b1);
    upd(B + 32'hFC, 1'b1, 1'b0); look("post_reset_last_entry", B + 32'hFC, 1'b1);

    // clear_req together with an update: sweep starts the following cycle
    step();
    bp_if.upd_valid = 1'b1;
    bp_if.upd_pc    = B + 32'h1C;
    bp_if.upd_taken = 1'b1;
    bp_if.clear_req = 1'b1;
    push("clear_with_update", 1'b1, 1'b1, 1'b0);
    step();
    bp_if.upd_valid = 1'b0;
    bp_if.clear_req = 1'b0;
    push("sweep_starts_next", 1'b0, 1'b0, 1'b1);
    for (int w = 0; w < 100 && bp_if.clear_busy; w++) step();
    checks++;
    if (bp_if.clear_busy !== 1'b0) begin
      errors++;
      $display("FAIL sweep_timeout: clear_busy got %b required 0", bp_if.clear_busy);
    end

`ifdef BP_STATS_EN
    for (int i = 0; i < 10; i++) upd(B + 32'h40 + 32'(i * 4), 1'b1, (i < 3));
    push_stats("stats_count", 32'd10, 32'd3);
    step();
    force dut.stat_branches_q = 32'hFFFF_FFFF;
    #1;
    release dut.stat_branches_q;
    upd(B, 1'b0, 1'b0);
    push_stats("stats_wrap", 32'd0, 32'd3);
`endif

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
